// File: rtl/arbitro_rr_salida.sv
// Round-robin drain of four class FIFOs into one output FIFO, with a registered output stage.
// Optional macro ARB_STRICT_PRIO_EN: class 3 wins whenever it is non-empty, and classes 0..2 share round-robin.
module arbitro_rr_salida #(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [3:0]        empty,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic              almost_full_out,
  output logic [3:0]        pop,
  output logic              push,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        class_out,
  output logic              idle,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1,
  output logic [CNT_W-1:0]  cnt2,
  output logic [CNT_W-1:0]  cnt3
);

  logic [DATA_W-1:0] din [4];
  logic              eligible;
  logic              grant_vld;
  logic [1:0]        grant_idx;
  logic [1:0]        rr_q, rr_d;
  logic              push_q, push_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        class_q, class_d;
  logic [CNT_W-1:0]  cnt_q [4];
  logic [CNT_W-1:0]  cnt_d [4];

  assign din[0] = data_in0;
  assign din[1] = data_in1;
  assign din[2] = data_in2;
  assign din[3] = data_in3;

  // reset_L gates the grant so no class FIFO is popped while reset is held
  assign eligible = reset_L & ~almost_full_out & (empty != 4'b1111);

`ifdef ARB_STRICT_PRIO_EN
  logic [2:0] cand;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    cand      = 3'd0;
    if (eligible) begin
      if (!empty[3]) begin
        grant_vld = 1'b1;
        grant_idx = 2'd3;
      end else begin
        // Scan backwards so the candidate closest to rr is the last one written
        for (int i = 2; i >= 0; i--) begin
          cand = {1'b0, rr_q} + 3'(i);
          if (cand >= 3'd3) cand = cand - 3'd3;
          if (!empty[cand[1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = cand[1:0];
          end
        end
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (grant_vld && grant_idx != 2'd3)
      rr_d = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
  end
`else
  logic [1:0] cand;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    cand      = 2'd0;
    if (eligible) begin
      for (int i = 3; i >= 0; i--) begin
        cand = rr_q + 2'(i);
        if (!empty[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  assign rr_d = grant_vld ? grant_idx + 2'd1 : rr_q;
`endif

  assign pop = grant_vld ? (4'b0001 << grant_idx) : 4'b0000;

  always_comb begin
    push_d  = grant_vld;
    data_d  = grant_vld ? din[grant_idx] : data_q;
    class_d = grant_vld ? grant_idx : class_q;
    for (int i = 0; i < 4; i++)
      cnt_d[i] = cnt_q[i] + CNT_W'(grant_vld && (grant_idx == 2'(i)));
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      push_q  <= 1'b0;
      data_q  <= '0;
      class_q <= 2'd0;
      rr_q    <= 2'd0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      push_q  <= push_d;
      data_q  <= data_d;
      class_q <= class_d;
      rr_q    <= rr_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign push      = push_q;
  assign data_out  = data_q;
  assign class_out = class_q;
  assign idle      = (empty == 4'b1111) & ~push_q;
  assign cnt0      = cnt_q[0];
  assign cnt1      = cnt_q[1];
  assign cnt2      = cnt_q[2];
  assign cnt3      = cnt_q[3];

endmodule

// File: tb/tb_arbitro_rr_salida.sv
// Scoreboard bench for arbitro_rr_salida: predicted words are queued at pop time and matched when push appears.
// Strict-priority scenarios run only when ARB_STRICT_PRIO_EN is defined.
module tb_arbitro_rr_salida;
  localparam int DATA_W = 10;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              reset_L;
  logic [3:0]        empty;
  logic [DATA_W-1:0] data_in0, data_in1, data_in2, data_in3;
  logic              almost_full_out;
  logic [3:0]        pop;
  logic              push;
  logic [DATA_W-1:0] data_out;
  logic [1:0]        class_out;
  logic              idle;
  logic [CNT_W-1:0]  cnt0, cnt1, cnt2, cnt3;

  typedef struct packed {
    logic [1:0]        cls;
    logic [DATA_W-1:0] data;
  } sb_t;

  sb_t               sb_q[$];
  sb_t               sb_exp;
  logic [DATA_W-1:0] din_v [4];
  int                checks = 0;
  int                errors = 0;
  int                tb_rr  = 0;

  assign data_in0 = din_v[0];
  assign data_in1 = din_v[1];
  assign data_in2 = din_v[2];
  assign data_in3 = din_v[3];

  always #5 clk = ~clk;

  arbitro_rr_salida #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_L(reset_L), .empty(empty),
    .data_in0(data_in0), .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
    .almost_full_out(almost_full_out), .pop(pop), .push(push),
    .data_out(data_out), .class_out(class_out), .idle(idle),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
  );

  // Output side of the scoreboard: every registered push must match the oldest predicted word
  always @(negedge clk) begin
    if (reset_L === 1'b1 && push === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_push: unexpected push data_out=%h class_out=%0d, required no push", data_out, class_out);
      end else begin
        sb_exp = sb_q.pop_front();
        if (data_out !== sb_exp.data || class_out !== sb_exp.cls) begin
          errors++;
          $display("FAIL sb_word: got data_out=%h class_out=%0d, required data_out=%h class_out=%0d",
                   data_out, class_out, sb_exp.data, sb_exp.cls);
        end
      end
    end
  end

  // Reference round-robin pick, written as a plain scan from the bench's own pointer
  function automatic logic [3:0] model_pop(input logic [3:0] e, input logic af);
    int c;
    if (af || e == 4'b1111) return 4'b0000;
    for (int k = 0; k < 4; k++) begin
      c = (tb_rr + k) % 4;
      if (!e[c]) return 4'b0001 << c;
    end
    return 4'b0000;
  endfunction

  task automatic apply(input logic [3:0] e, input logic af);
    @(negedge clk);
    #1;
    empty           = e;
    almost_full_out = af;
    for (int k = 0; k < 4; k++) din_v[k] = DATA_W'($urandom);
    #1;
  endtask

  task automatic accept(input logic [3:0] p);
    for (int c = 0; c < 4; c++) begin
      if (p[c]) begin
        sb_q.push_back({2'(c), din_v[c]});
        tb_rr = (c + 1) % 4;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset_L = 1'b0;
    empty   = 4'b1111;
    @(negedge clk);
    #1;
    reset_L = 1'b1;
    tb_rr   = 0;
    sb_q.delete();
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    empty = 4'b0000;
    almost_full_out = 1'b0;
    for (int k = 0; k < 4; k++) din_v[k] = '0;
    #3;
    checks++;
    if (pop !== 4'b0000 || push !== 1'b0 || data_out !== '0) begin
      errors++;
      $display("FAIL reset_hold: pop=%b push=%b data_out=%h, required pop=0000 push=0 data_out=000", pop, push, data_out);
    end
    @(negedge clk);
    #1;
    empty = 4'b1111;
    reset_L = 1'b1;
    for (int i = 0; i < 5; i++) begin
      apply(4'b1111, 1'b0);
      checks++;
      if (pop !== 4'b0000 || push !== 1'b0 || idle !== 1'b1 || {cnt0, cnt1, cnt2, cnt3} !== '0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: pop=%b push=%b idle=%b cnts=%0d/%0d/%0d/%0d, required 0000 0 1 0/0/0/0",
                 i, pop, push, idle, cnt0, cnt1, cnt2, cnt3);
      end
    end
  endtask

  task automatic test_single_word();
    apply(4'b1101, 1'b0);
    din_v[1] = 10'h155;
    #1;
    checks++;
    if (pop !== 4'b0010) begin
      errors++;
      $display("FAIL single_pop: pop=%b, required 0010", pop);
    end
    accept(4'b0010);
    apply(4'b1111, 1'b0);
    checks++;
    if (push !== 1'b1 || data_out !== 10'h155 || class_out !== 2'd1 || cnt1 !== 8'd1) begin
      errors++;
      $display("FAIL single_out: push=%b data_out=%h class_out=%0d cnt1=%0d, required 1 155 1 1",
               push, data_out, class_out, cnt1);
    end
    // Pointer should now sit at class 2
    apply(4'b0000, 1'b0);
    checks++;
    if (pop !== 4'b0100) begin
      errors++;
      $display("FAIL single_rr: pop=%b, required 0100", pop);
    end
    accept(pop);
    apply(4'b1111, 1'b0);
  endtask

  task automatic test_fairness();
    logic [3:0] seq [4];
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply(4'b0000, 1'b0);
      checks++;
      if (pop !== seq[i % 4]) begin
        errors++;
        $display("FAIL fair_pop cycle %0d: pop=%b, required %b", i, pop, seq[i % 4]);
      end
      if (i > 0) begin
        checks++;
        if (push !== 1'b1) begin
          errors++;
          $display("FAIL fair_push cycle %0d: push=%b, required 1", i, push);
        end
      end
      accept(seq[i % 4]);
    end
    apply(4'b1111, 1'b0);
    checks++;
    if (push !== 1'b1 || idle !== 1'b0 || cnt0 !== 8'd2 || cnt1 !== 8'd2 || cnt2 !== 8'd2 || cnt3 !== 8'd2) begin
      errors++;
      $display("FAIL fair_end: push=%b idle=%b cnts=%0d/%0d/%0d/%0d, required 1 0 2/2/2/2",
               push, idle, cnt0, cnt1, cnt2, cnt3);
    end
    apply(4'b1111, 1'b0);
    checks++;
    if (push !== 1'b0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL fair_idle: push=%b idle=%b, required 0 1", push, idle);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_pop;
    logic       prev_grant = 1'b0;
    logic       af;
    for (int i = 0; i < 10; i++) begin
      af = (i >= 3 && i <= 5);
      apply(4'b0000, af);
      exp_pop = model_pop(4'b0000, af);
      checks++;
      if (pop !== exp_pop) begin
        errors++;
        $display("FAIL bp_pop cycle %0d: pop=%b, required %b", i, pop, exp_pop);
      end
      checks++;
      if (push !== prev_grant) begin
        errors++;
        $display("FAIL bp_push cycle %0d: push=%b, required %b", i, push, prev_grant);
      end
      accept(exp_pop);
      prev_grant = (exp_pop != 4'b0000);
    end
    apply(4'b1111, 1'b0);
    apply(4'b1111, 1'b0);
  endtask

  task automatic test_skip();
    logic [3:0] pat [8];
    logic [3:0] exp_pop;
    pat[0] = 4'b1010; pat[1] = 4'b1010; pat[2] = 4'b1010; pat[3] = 4'b0110;
    pat[4] = 4'b0111; pat[5] = 4'b1101; pat[6] = 4'b0011; pat[7] = 4'b1110;
    for (int i = 0; i < 8; i++) begin
      apply(pat[i], 1'b0);
      exp_pop = model_pop(pat[i], 1'b0);
      checks++;
      if (pop !== exp_pop) begin
        errors++;
        $display("FAIL skip_pop cycle %0d: empty=%b pop=%b, required %b", i, pat[i], pop, exp_pop);
      end
      if (i > 0) begin
        checks++;
        if (push !== 1'b1) begin
          errors++;
          $display("FAIL skip_bubble cycle %0d: push=%b, required 1", i, push);
        end
      end
      accept(exp_pop);
    end
    apply(4'b1111, 1'b0);
    apply(4'b1111, 1'b0);
  endtask

  task automatic test_reset_mid();
    apply(4'b0000, 1'b0);
    accept(model_pop(4'b0000, 1'b0));
    apply(4'b0000, 1'b0);
    checks++;
    if (push !== 1'b1) begin
      errors++;
      $display("FAIL mid_prepush: push=%b, required 1", push);
    end
    #2;
    reset_L = 1'b0;
    #1;
    checks++;
    if (push !== 1'b0 || data_out !== '0 || class_out !== 2'd0 || pop !== 4'b0000 || {cnt0, cnt1, cnt2, cnt3} !== '0) begin
      errors++;
      $display("FAIL mid_clear: push=%b data_out=%h class_out=%0d pop=%b cnts=%0d/%0d/%0d/%0d, required all zero",
               push, data_out, class_out, pop, cnt0, cnt1, cnt2, cnt3);
    end
    sb_q.delete();
    tb_rr = 0;
    @(negedge clk);
    #1;
    checks++;
    if (pop !== 4'b0000) begin
      errors++;
      $display("FAIL mid_hold: pop=%b, required 0000", pop);
    end
    reset_L = 1'b1;
    #1;
    checks++;
    if (pop !== 4'b0001) begin
      errors++;
      $display("FAIL mid_first: pop=%b, required 0001", pop);
    end
    accept(4'b0001);
    apply(4'b1111, 1'b0);
    apply(4'b1111, 1'b0);
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      apply(4'b1110, 1'b0);
      if (i == 255) begin
        checks++;
        if (cnt0 !== 8'd255) begin
          errors++;
          $display("FAIL wrap_pre: cnt0=%0d, required 255", cnt0);
        end
      end
      checks++;
      if (pop !== 4'b0001) begin
        errors++;
        $display("FAIL wrap_pop cycle %0d: pop=%b, required 0001", i, pop);
      end
      accept(4'b0001);
    end
    apply(4'b1111, 1'b0);
    checks++;
    if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin
      errors++;
      $display("FAIL wrap_cnt: cnt0=%0d cnt1=%0d, required 0 0", cnt0, cnt1);
    end
    apply(4'b1111, 1'b0);
  endtask

`ifdef ARB_STRICT_PRIO_EN
  task automatic test_strict_prio();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(4'b0110, 1'b0);
      checks++;
      if (pop !== 4'b1000) begin
        errors++;
        $display("FAIL strict_pop cycle %0d: pop=%b, required 1000", i, pop);
      end
      if (pop == 4'b1000) sb_q.push_back({2'd3, din_v[3]});
    end
    apply(4'b1110, 1'b0);
    checks++;
    if (pop !== 4'b0001) begin
      errors++;
      $display("FAIL strict_low: pop=%b, required 0001", pop);
    end
    if (pop == 4'b0001) sb_q.push_back({2'd0, din_v[0]});
    apply(4'b1111, 1'b0);
    apply(4'b1111, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
`ifdef ARB_STRICT_PRIO_EN
    test_strict_prio();
`else
    test_single_word();
    test_fairness();
    test_backpressure();
    test_skip();
    test_reset_mid();
    test_wrap();
`endif
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d words never pushed, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arbitro_rr_salida.md
Name: arbitro_rr_salida

Overview:
- Downstream neighbour of the class-steering arbiter: drains the four per-class FIFOs (class 0..3) into a single output FIFO.
- Selects one non-empty class per cycle with a registered round-robin pointer.
- Pops the chosen class FIFO, and registers the word and its class onto the output FIFO write port.
- Holds off entirely while the output FIFO reports almost_full.

Parameters:
- DATA_W, 10, width of one FIFO word (payload including the class bits).
- CNT_W, 8, width of each per-class transfer counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- empty  input  4  empty flags of class FIFOs 3..0.
- data_in0..data_in3  input  DATA_W each  first-word-fall-through outputs of class FIFOs 0..3; valid whenever the matching empty bit is 0.
- almost_full_out  input  1  almost_full flag of the output FIFO.
- pop  output  4  one-hot pop to class FIFOs; combinational.
- push  output  1  write enable to the output FIFO; registered.
- data_out  output  DATA_W  word to the output FIFO; registered.
- class_out  output  2  class index of data_out; registered.
- idle  output  1  high when all class FIFOs are empty and push is 0.
- cnt0..cnt3  output  CNT_W each  number of words forwarded per class; registered.

Behaviour:
- Reset (reset_L=0, asynchronous):
  - push=0, data_out=0, class_out=0, cnt0..3=0, round-robin pointer rr=0.
  - pop is forced to 0 while reset_L=0.
- Eligibility: grant is allowed iff reset_L=1, almost_full_out=0, and empty != 4'b1111.
- Grant selection: first non-empty class scanning rr, rr+1, rr+2, rr+3 (mod 4).
  - pop = one-hot of the grant in the same cycle; otherwise pop=0.
  - At most one pop bit is high in any cycle.
- On the edge where pop[k]=1:
  - data_out<=data_ink, class_out<=k, push<=1.
  - rr<=(k+1) mod 4.
  - cntk<=cntk+1; wraps to 0 past 2^CNT_W-1 with no saturation and no flag.
- On an edge with no grant:
  - push<=0; data_out and class_out hold their last value; rr holds.
- Latency and throughput:
  - Word popped at edge N appears on data_out with push=1 during cycle N+1.
  - Sustained throughput is 1 word/clock.
- Back-pressure:
  - almost_full_out is sampled combinationally and blocks pop in the same cycle.
  - The output FIFO's almost_full threshold must leave at least 1 free entry for the in-flight registered word.
  - A push already registered still completes when almost_full rises.
- Fairness:
  - With all four classes continuously non-empty, the grant order is 0,1,2,3,0,...
  - A class becoming empty is skipped with no bubble cycle.
- State: one registered stage (push, data_out, class_out) plus rr; no multi-state FSM beyond grant and idle.
- Reset mid-transfer:
  - Any registered push is dropped immediately; push goes to 0 asynchronously.
  - pop deasserts immediately; no class FIFO is popped during reset.
  - The first grant after reset_L rises starts at class 0.
- idle = (empty==4'b1111) & ~push; combinational.

Optional Feature:
- Macro: ARB_STRICT_PRIO_EN.
- Defined:
  - Class 3 has strict priority: whenever empty[3]=0 and eligibility holds, pop=4'b1000.
  - Classes 0..2 share the remaining slots round-robin; rr covers classes 0..2 only.
- Undefined: pure 4-way round-robin as above.
- Ports are identical in both builds.

Test Plan:
- Reset release, empty=4'b1111 → pop=0, push=0, idle=1, cnt0..3=0 for 5 cycles.
- Single word: empty=4'b1101, data_in1=10'h155 for one pop → pop=4'b0010 at edge N; next cycle push=1, data_out=10'h155, class_out=1; cnt1=1; rr=2.
- All four classes non-empty for 8 cycles → pop sequence 0001,0010,0100,1000 repeated twice; cnt0..3=2 each; push high 8 consecutive cycles.
- almost_full_out=1 for cycles 3-5 with all classes non-empty → pop=0 in those cycles; push drops one cycle later; round-robin order resumes where it stopped.
- reset_L pulsed low mid-stream with push=1 → push, data_out, cnt and rr clear at once; first grant after release is class 0.
- ARB_STRICT_PRIO_EN defined, classes 3 and 0 both non-empty for 4 cycles → pop=4'b1000 all 4 cycles; class 0 granted only after empty[3]=1.
- cnt0 wrap: 256 class-0 words with CNT_W=8 → cnt0 reads 0 afterwards.
